bj_predict_unit: RTL and testbench
==================================

BJ_PREDICT_UNIT -- requirements
Module: bj_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: address and data width.
REQ-002 SHALL have parameter BTB_DEPTH, default 16: entry count, power of two, 2 to 256.
REQ-003 SHALL have clock CLK input 1: all state on its rising edge; one clock.
REQ-004 SHALL have reset RESETN input 1: asynchronous, active-low.
REQ-005 SHALL have IF_PC input XLEN: fetch PC for lookup.
REQ-006 SHALL have PRED_TAKEN output 1 and PRED_PC output XLEN: combinational prediction for IF_PC.
REQ-007 SHALL have EX_VALID input 1: resolve-stage instruction valid.
REQ-008 SHALL have EX_PC, EX_IMM and EX_RS1, each input XLEN: resolve-stage operands.
REQ-009 SHALL have BJ_CTRL input 2: 00 none, 01 branch, 10 JAL, 11 JALR.
REQ-010 SHALL have FUNC3 input 3, and ZERO, SIGN_BIT and SLTU_BIT inputs 1 each: ALU compare flags.
REQ-011 SHALL have EX_PRED_TAKEN input 1 and EX_PRED_PC input XLEN: prediction carried down the pipe.
REQ-012 SHALL have B_PC output XLEN and BRANCH_SEL output 1: combinational resolved target and actual-taken.
REQ-013 SHALL have FLUSH output 1 and REDIRECT_PC output XLEN: registered mispredict redirect.

Function
REQ-014 Conditions SHALL be: BEQ=ZERO, BNE=~ZERO, BLT=SIGN_BIT, BGE=~SIGN_BIT, BLTU=SLTU_BIT, BGEU=~SLTU_BIT.
REQ-015 Conditions SHALL NOT depend on ZERO except for BEQ and BNE.
REQ-016 FUNC3 values 010 and 011 SHALL resolve not-taken.
REQ-017 BRANCH_SEL SHALL be 1 in these cases: BJ_CTRL=01 and the condition holds; BJ_CTRL=10; or BJ_CTRL=11.
REQ-018 BRANCH_SEL SHALL be gated by EX_VALID.
REQ-019 B_PC SHALL be EX_PC+EX_IMM for BJ_CTRL=01 or 10, and (EX_RS1+EX_IMM) with bit 0 cleared for BJ_CTRL=11; all sums are modulo 2^XLEN.
REQ-020 Each entry SHALL hold valid, tag = PC[XLEN-1:IW+2], target, a jump flag and a 2-bit counter (SNT=00, WNT=01, WT=10, ST=11); index = PC[IW+1:2], IW = log2(BTB_DEPTH).
REQ-021 On a lookup hit (valid and tag match), PRED_TAKEN SHALL be 1 if the jump flag is set or counter[1] is set, and PRED_PC SHALL be the stored target.
REQ-022 On a lookup miss, PRED_TAKEN SHALL be 0 and PRED_PC SHALL be IF_PC+4.
REQ-023 Mispredict SHALL be defined as EX_VALID and (BRANCH_SEL != EX_PRED_TAKEN, or both taken and B_PC != EX_PRED_PC).
REQ-024 One cycle after a mispredict, FLUSH SHALL be 1 for exactly one cycle, with REDIRECT_PC = B_PC if taken, else EX_PC+4.
REQ-025 When FLUSH is 0, REDIRECT_PC SHALL hold its previous value.
REQ-026 Table update SHALL occur at the clock edge when EX_VALID=1 and BJ_CTRL is 01 or 10; BJ_CTRL=11 SHALL never allocate or update.
REQ-027 Branch hit, taken: counter SHALL increment, saturating at ST, and target SHALL be rewritten.
REQ-028 Branch hit, not-taken: counter SHALL decrement, saturating at SNT.
REQ-029 Branch miss, taken: SHALL allocate with valid=1, tag, target, counter=WT, jump=0; any occupant is overwritten.
REQ-030 Branch miss, not-taken: no table change.
REQ-031 JAL: SHALL allocate or overwrite with jump=1, counter=ST.
REQ-032 A same-cycle lookup and update of the same index SHALL return pre-update contents (no bypass).
REQ-033 Back-to-back mispredicts SHALL each produce a FLUSH pulse, so FLUSH may stay high on consecutive cycles with REDIRECT_PC updated each cycle.

Reset
REQ-034 RESETN low SHALL immediately clear all valid bits, set all counters to WNT, FLUSH=0, REDIRECT_PC=0 and performance counters to 0, regardless of activity in flight.
REQ-035 A resolve in the cycle RESETN deasserts SHALL be processed normally.

Configuration
REQ-036 With BJ_PERF_CNT_EN defined, outputs BR_CNT and MISS_CNT (each 32 bits) SHALL count EX_VALID branches/jumps and mispredicts respectively, saturating at 32'hFFFFFFFF.
REQ-037 With BJ_PERF_CNT_EN undefined, those ports and registers SHALL be absent.

Structure
REQ-038 Package bj_pkg SHALL hold the BJ_CTRL encodings, FUNC3 branch codes and counter state typedef/constants.
REQ-039 Sub-module bj_sat_counter (2-bit saturating inc/dec) SHALL be instantiated once, in the update path.

Verification
REQ-040 BEQ at PC 0x100, IMM 0x20, ZERO=1, pred 0 -> BRANCH_SEL=1, B_PC=0x120; next cycle FLUSH=1, REDIRECT_PC=0x120; entry allocated WT.
REQ-041 Lookup IF_PC=0x100 after REQ-040 -> PRED_TAKEN=1, PRED_PC=0x120; a not-taken resolve -> WNT, then PRED_TAKEN=0; FLUSH with REDIRECT_PC=0x104.
REQ-042 JALR with RS1=0x2001, IMM=4 -> B_PC=0x2004; never allocates; FLUSH when pred 0.
REQ-043 Four taken BLTU at 0x40 with SLTU_BIT=1 -> counter saturates at ST; BLT with SIGN_BIT=1 and ZERO=1 -> taken.
REQ-044 RESETN pulsed low mid-stream with FLUSH=1 -> FLUSH=0 immediately; every lookup misses afterwards.
REQ-045 With BJ_PERF_CNT_EN, 3 resolves including 2 mispredicts -> BR_CNT=3, MISS_CNT=2.

Source files
------------

// File: rtl/bj_pkg.sv
// rtl/bj_pkg.sv - encodings, counter states and branch-condition helper for the predict unit
package bj_pkg;

  localparam logic [1:0] BJ_NONE   = 2'b00;
  localparam logic [1:0] BJ_BRANCH = 2'b01;
  localparam logic [1:0] BJ_JAL    = 2'b10;
  localparam logic [1:0] BJ_JALR   = 2'b11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_WT  = 2'b10;
  localparam cnt_t CNT_ST  = 2'b11;

  // Only BEQ/BNE look at ZERO; unassigned func3 codes never take.
  function automatic logic bj_cond(input logic [2:0] func3, input logic zero,
                                   input logic sign_bit, input logic sltu_bit);
    logic c;
    c = 1'b0;
    case (func3)
      F3_BEQ:  c = zero;
      F3_BNE:  c = ~zero;
      F3_BLT:  c = sign_bit;
      F3_BGE:  c = ~sign_bit;
      F3_BLTU: c = sltu_bit;
      F3_BGEU: c = ~sltu_bit;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bj_sat_counter.sv
// rtl/bj_sat_counter.sv - 2-bit saturating up/down counter next-state
module bj_sat_counter (
  input  logic [1:0] cur,
  input  logic       up,
  output logic [1:0] nxt
);
  import bj_pkg::*;

  always_comb begin
    nxt = cur;
    if (up) begin
      if (cur != CNT_ST) nxt = cur + 2'd1;
    end else if (cur != CNT_SNT) begin
      nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/bj_predict_unit.sv
// rtl/bj_predict_unit.sv - BTB lookup, branch/jump resolve and mispredict redirect
// Optional BR_CNT/MISS_CNT performance counters under `define BJ_PERF_CNT_EN.
module bj_predict_unit #(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 16
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic [XLEN-1:0] IF_PC,
  output logic            PRED_TAKEN,
  output logic [XLEN-1:0] PRED_PC,
  input  logic            EX_VALID,
  input  logic [XLEN-1:0] EX_PC,
  input  logic [XLEN-1:0] EX_IMM,
  input  logic [XLEN-1:0] EX_RS1,
  input  logic [1:0]      BJ_CTRL,
  input  logic [2:0]      FUNC3,
  input  logic            ZERO,
  input  logic            SIGN_BIT,
  input  logic            SLTU_BIT,
  input  logic            EX_PRED_TAKEN,
  input  logic [XLEN-1:0] EX_PRED_PC,
  output logic [XLEN-1:0] B_PC,
  output logic            BRANCH_SEL,
  output logic            FLUSH,
  output logic [XLEN-1:0] REDIRECT_PC
`ifdef BJ_PERF_CNT_EN
  ,
  output logic [31:0]     BR_CNT,
  output logic [31:0]     MISS_CNT
`endif
);
  import bj_pkg::*;

  localparam int IW = $clog2(BTB_DEPTH);
  localparam int TW = XLEN - IW - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [BTB_DEPTH-1:0] ent_valid;
  logic [BTB_DEPTH-1:0] ent_jump;
  logic [TW-1:0]        ent_tag    [BTB_DEPTH];
  logic [XLEN-1:0]      ent_target [BTB_DEPTH];
  cnt_t                 ent_cnt    [BTB_DEPTH];

  logic [IW-1:0]   if_idx, ex_idx;
  logic [TW-1:0]   if_tag, ex_tag;
  logic            if_hit, ex_hit;
  logic            taken, mispredict;
  logic [XLEN-1:0] jalr_sum;
  logic            upd_branch, upd_jal, alloc;
  cnt_t            cnt_next;

  assign if_idx = IF_PC[IW+1:2];
  assign if_tag = IF_PC[XLEN-1:IW+2];
  assign ex_idx = EX_PC[IW+1:2];
  assign ex_tag = EX_PC[XLEN-1:IW+2];

  // Reads the table as it stood before this cycle's update edge.
  assign if_hit     = ent_valid[if_idx] && (ent_tag[if_idx] == if_tag);
  assign PRED_TAKEN = if_hit && (ent_jump[if_idx] || ent_cnt[if_idx][1]);
  assign PRED_PC    = if_hit ? ent_target[if_idx] : IF_PC + PC_STEP;

  assign jalr_sum = EX_RS1 + EX_IMM;

  always_comb begin
    taken = 1'b0;
    B_PC  = EX_PC + EX_IMM;
    case (BJ_CTRL)
      BJ_NONE:   taken = 1'b0;
      BJ_BRANCH: taken = bj_cond(FUNC3, ZERO, SIGN_BIT, SLTU_BIT);
      BJ_JAL:    taken = 1'b1;
      BJ_JALR: begin
        taken = 1'b1;
        B_PC  = {jalr_sum[XLEN-1:1], 1'b0};
      end
    endcase
  end

  assign BRANCH_SEL = EX_VALID && taken;
  assign mispredict = EX_VALID &&
                      ((BRANCH_SEL != EX_PRED_TAKEN) ||
                       (BRANCH_SEL && EX_PRED_TAKEN && (B_PC != EX_PRED_PC)));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      FLUSH       <= 1'b0;
      REDIRECT_PC <= '0;
    end else begin
      FLUSH <= mispredict;
      if (mispredict) REDIRECT_PC <= BRANCH_SEL ? B_PC : EX_PC + PC_STEP;
    end
  end

  // JALR targets are register-dependent, so they never enter the table.
  assign ex_hit     = ent_valid[ex_idx] && (ent_tag[ex_idx] == ex_tag);
  assign upd_branch = EX_VALID && (BJ_CTRL == BJ_BRANCH);
  assign upd_jal    = EX_VALID && (BJ_CTRL == BJ_JAL);
  assign alloc      = upd_jal || (upd_branch && !ex_hit && taken);

  bj_sat_counter u_sat_counter (
    .cur (ent_cnt[ex_idx]),
    .up  (taken),
    .nxt (cnt_next)
  );

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ent_valid <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) ent_cnt[i] <= CNT_WNT;
    end else if (alloc) begin
      ent_valid[ex_idx] <= 1'b1;
      ent_cnt[ex_idx]   <= upd_jal ? CNT_ST : CNT_WT;
    end else if (upd_branch && ex_hit) begin
      ent_cnt[ex_idx] <= cnt_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (alloc) begin
      ent_tag[ex_idx]    <= ex_tag;
      ent_target[ex_idx] <= B_PC;
      ent_jump[ex_idx]   <= upd_jal;
    end else if (upd_branch && ex_hit && taken) begin
      ent_target[ex_idx] <= B_PC;
    end
  end

`ifdef BJ_PERF_CNT_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      BR_CNT   <= '0;
      MISS_CNT <= '0;
    end else begin
      if (EX_VALID && (BJ_CTRL != BJ_NONE) && (BR_CNT != 32'hFFFF_FFFF)) BR_CNT <= BR_CNT + 32'd1;
      if (mispredict && (MISS_CNT != 32'hFFFF_FFFF)) MISS_CNT <= MISS_CNT + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bj_predict_unit.sv
// tb/tb_bj_predict_unit.sv - scoreboard bench for bj_predict_unit against a table model
module tb_bj_predict_unit;

  localparam int D  = 16;
  localparam int IW = 4;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic [31:0] IF_PC = 32'h100;
  logic        PRED_TAKEN;
  logic [31:0] PRED_PC;
  logic        EX_VALID = 1'b0;
  logic [31:0] EX_PC = '0, EX_IMM = '0, EX_RS1 = '0, EX_PRED_PC = '0;
  logic [1:0]  BJ_CTRL = 2'b00;
  logic [2:0]  FUNC3 = 3'b000;
  logic        ZERO = 1'b0, SIGN_BIT = 1'b0, SLTU_BIT = 1'b0, EX_PRED_TAKEN = 1'b0;
  logic [31:0] B_PC;
  logic        BRANCH_SEL;
  logic        FLUSH;
  logic [31:0] REDIRECT_PC;
`ifdef BJ_PERF_CNT_EN
  logic [31:0] BR_CNT, MISS_CNT;
`endif

  bj_predict_unit #(.XLEN(32), .BTB_DEPTH(D)) dut (
    .CLK(CLK), .RESETN(RESETN), .IF_PC(IF_PC), .PRED_TAKEN(PRED_TAKEN), .PRED_PC(PRED_PC),
    .EX_VALID(EX_VALID), .EX_PC(EX_PC), .EX_IMM(EX_IMM), .EX_RS1(EX_RS1), .BJ_CTRL(BJ_CTRL),
    .FUNC3(FUNC3), .ZERO(ZERO), .SIGN_BIT(SIGN_BIT), .SLTU_BIT(SLTU_BIT),
    .EX_PRED_TAKEN(EX_PRED_TAKEN), .EX_PRED_PC(EX_PRED_PC), .B_PC(B_PC),
    .BRANCH_SEL(BRANCH_SEL), .FLUSH(FLUSH), .REDIRECT_PC(REDIRECT_PC)
`ifdef BJ_PERF_CNT_EN
    , .BR_CNT(BR_CNT), .MISS_CNT(MISS_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct { logic ptak; logic [31:0] ppc; logic bsel; logic [31:0] bpc; } comb_exp_t;
  typedef struct { logic flush; logic [31:0] rpc; logic [31:0] br; logic [31:0] miss; } reg_exp_t;
  comb_exp_t cq[$];
  reg_exp_t  rq[$];
  comb_exp_t mon_c;
  reg_exp_t  mon_r;

  bit          m_valid [D];
  bit          m_jump  [D];
  int unsigned m_cnt   [D];
  logic [31:0] m_tag   [D];
  logic [31:0] m_tgt   [D];
  logic [31:0] m_redirect;
  int unsigned m_br, m_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_redirect = '0;
    m_br = 0;
    m_miss = 0;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(D));
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int i;
    i = idx_of(pc);
    if (m_valid[i] && m_tag[i] == (pc >> (IW + 2))) begin
      tk = m_jump[i] || (m_cnt[i] >= 2);
      tg = m_tgt[i];
    end else begin
      tk = 1'b0;
      tg = pc + 32'd4;
    end
  endfunction

  function automatic bit m_cond(input logic [2:0] f3, input bit z, input bit s, input bit u);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return s;
      3'b101:  return !s;
      3'b110:  return u;
      3'b111:  return !u;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit v, input logic [1:0] ctrl, input logic [2:0] f3,
                      input bit z, input bit s, input bit u,
                      input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                      input bit ptak, input logic [31:0] ppc, input logic [31:0] ifpc);
    comb_exp_t   ce;
    reg_exp_t    re;
    bit          tk, mis, hit;
    logic        lt;
    logic [31:0] lp, bpc;
    int          i;
    @(negedge CLK);
    RESETN = 1'b1;
    EX_VALID = v; BJ_CTRL = ctrl; FUNC3 = f3; ZERO = z; SIGN_BIT = s; SLTU_BIT = u;
    EX_PC = pc; EX_IMM = imm; EX_RS1 = rs1; EX_PRED_TAKEN = ptak; EX_PRED_PC = ppc; IF_PC = ifpc;

    tk  = v && ((ctrl == 2'b01 && m_cond(f3, z, s, u)) || ctrl == 2'b10 || ctrl == 2'b11);
    bpc = (ctrl == 2'b11) ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
    m_lookup(ifpc, lt, lp);
    ce.ptak = lt; ce.ppc = lp; ce.bsel = tk; ce.bpc = bpc;
    cq.push_back(ce);

    mis = v && ((tk != ptak) || (tk && ptak && bpc != ppc));
    if (mis) m_redirect = tk ? bpc : pc + 32'd4;
    if (v && ctrl != 2'b00) m_br++;
    if (mis) m_miss++;
    re.flush = mis; re.rpc = m_redirect; re.br = m_br; re.miss = m_miss;
    rq.push_back(re);

    i = idx_of(pc);
    hit = m_valid[i] && m_tag[i] == (pc >> (IW + 2));
    if (v && ctrl == 2'b01) begin
      if (hit) begin
        if (tk) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_tgt[i] = bpc;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (tk) begin
        m_valid[i] = 1'b1; m_tag[i] = pc >> (IW + 2); m_tgt[i] = bpc; m_jump[i] = 1'b0; m_cnt[i] = 2;
      end
    end else if (v && ctrl == 2'b10) begin
      m_valid[i] = 1'b1; m_tag[i] = pc >> (IW + 2); m_tgt[i] = bpc; m_jump[i] = 1'b1; m_cnt[i] = 3;
    end
  endtask

  task automatic idle(input logic [31:0] ifpc);
    step(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, ifpc);
  endtask

  // Combinational outputs are sampled mid-low-phase, before the update edge.
  initial forever begin
    @(negedge CLK);
    #2;
    if (cq.size() > 0) begin
      mon_c = cq.pop_front();
      check("pred_taken", {31'b0, PRED_TAKEN}, {31'b0, mon_c.ptak});
      check("pred_pc", PRED_PC, mon_c.ppc);
      check("branch_sel", {31'b0, BRANCH_SEL}, {31'b0, mon_c.bsel});
      check("b_pc", B_PC, mon_c.bpc);
    end
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (rq.size() > 0) begin
      mon_r = rq.pop_front();
      check("flush", {31'b0, FLUSH}, {31'b0, mon_r.flush});
      check("redirect_pc", REDIRECT_PC, mon_r.rpc);
`ifdef BJ_PERF_CNT_EN
      check("br_cnt", BR_CNT, mon_r.br);
      check("miss_cnt", MISS_CNT, mon_r.miss);
`endif
    end
  end

  logic [31:0] pcs [8];
  logic        lt;
  logic [31:0] lp;

  initial begin
    pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h140; pcs[3] = 32'h180;
    pcs[4] = 32'h10c; pcs[5] = 32'h3f0; pcs[6] = 32'h200; pcs[7] = 32'h108;

    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    check("rst_flush", {31'b0, FLUSH}, 32'd0);
    check("rst_redirect", REDIRECT_PC, 32'h0);
    check("rst_pred_taken", {31'b0, PRED_TAKEN}, 32'd0);
    check("rst_pred_pc", PRED_PC, 32'h104);

    // BEQ taken, unpredicted, resolved in the reset-release cycle
    step(1, 2'b01, 3'b000, 1, 0, 0, 32'h100, 32'h20, 32'h0, 0, 32'h0, 32'h100);
    #1;
    check("beq_bsel", {31'b0, BRANCH_SEL}, 32'd1);
    check("beq_bpc", B_PC, 32'h120);
    idle(32'h100);
    #1;
    check("beq_flush", {31'b0, FLUSH}, 32'd1);
    check("beq_redirect", REDIRECT_PC, 32'h120);
    check("beq_lookup_tk", {31'b0, PRED_TAKEN}, 32'd1);
    check("beq_lookup_pc", PRED_PC, 32'h120);
    step(1, 2'b01, 3'b000, 0, 0, 0, 32'h100, 32'h20, 32'h0, 1, 32'h120, 32'h100);
    idle(32'h100);
    #1;
    check("nt_lookup_tk", {31'b0, PRED_TAKEN}, 32'd0);
    check("nt_redirect", REDIRECT_PC, 32'h104);

    // JALR pair: back-to-back mispredicts, never allocated
    step(1, 2'b11, 3'b000, 0, 0, 0, 32'h300, 32'h4, 32'h2001, 0, 32'h0, 32'h300);
    #1;
    check("jalr_bpc", B_PC, 32'h2004);
    step(1, 2'b11, 3'b000, 0, 0, 0, 32'h304, 32'h8, 32'h3000, 0, 32'h0, 32'h300);
    #1;
    check("b2b_flush1", {31'b0, FLUSH}, 32'd1);
    check("b2b_redirect1", REDIRECT_PC, 32'h2004);
    idle(32'h300);
    #1;
    check("b2b_flush2", {31'b0, FLUSH}, 32'd1);
    check("b2b_redirect2", REDIRECT_PC, 32'h3008);
    check("jalr_no_alloc", {31'b0, PRED_TAKEN}, 32'd0);

    // Four taken BLTU saturate at ST; one not-taken still predicts taken
    repeat (4) begin
      m_lookup(32'h40, lt, lp);
      step(1, 2'b01, 3'b110, 0, 0, 1, 32'h40, 32'h10, 32'h0, lt, lp, 32'h40);
    end
    m_lookup(32'h40, lt, lp);
    step(1, 2'b01, 3'b110, 0, 0, 0, 32'h40, 32'h10, 32'h0, lt, lp, 32'h40);
    idle(32'h40);
    #1;
    check("bltu_sat_tk", {31'b0, PRED_TAKEN}, 32'd1);
    step(1, 2'b01, 3'b100, 1, 1, 0, 32'h80, 32'h40, 32'h0, 0, 32'h0, 32'h80);
    #1;
    check("blt_taken", {31'b0, BRANCH_SEL}, 32'd1);
    step(1, 2'b01, 3'b010, 1, 1, 1, 32'h84, 32'h40, 32'h0, 0, 32'h0, 32'h80);
    #1;
    check("f3_010_nt", {31'b0, BRANCH_SEL}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc, imm, ppc;
      logic [1:0]  ctrl;
      bit          ptak;
      pc   = pcs[$urandom_range(0, 7)];
      ctrl = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       imm = 32'h20;
        1:       imm = 32'hFFFF_FFF8;
        2:       imm = 32'h400;
        default: imm = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        m_lookup(pc, lt, lp);
        ptak = lt; ppc = lp;
      end else begin
        ptak = 1'($urandom_range(0, 1));
        ppc  = ($urandom_range(0, 1) == 1) ? pc + imm : pc + 32'd4;
      end
      step($urandom_range(0, 9) != 0, ctrl, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           pc, imm, $urandom, ptak, ppc, pcs[$urandom_range(0, 7)]);
    end

    // Asynchronous reset while a flush is being presented
    step(1, 2'b10, 3'b000, 0, 0, 0, 32'h500, 32'h40, 32'h0, 0, 32'h0, 32'h500);
    @(posedge CLK);
    #2;
    check("pre_rst_flush", {31'b0, FLUSH}, 32'd1);
    RESETN = 1'b0;
    #1;
    check("async_rst_flush", {31'b0, FLUSH}, 32'd0);
    check("async_rst_redirect", REDIRECT_PC, 32'h0);
    model_reset();
    idle(32'h500);
    #1;
    check("post_rst_miss_500", {31'b0, PRED_TAKEN}, 32'd0);
    idle(32'h40);
    #1;
    check("post_rst_miss_40", {31'b0, PRED_TAKEN}, 32'd0);
    idle(32'h100);
    #1;
    check("post_rst_miss_100", {31'b0, PRED_TAKEN}, 32'd0);

    step(1, 2'b10, 3'b000, 0, 0, 0, 32'h600, 32'h10, 32'h0, 0, 32'h0, 32'h600);
    step(1, 2'b01, 3'b000, 0, 0, 0, 32'h604, 32'h10, 32'h0, 0, 32'h0, 32'h600);
    step(1, 2'b11, 3'b000, 0, 0, 0, 32'h608, 32'h10, 32'h700, 0, 32'h0, 32'h600);
    idle(32'h600);
`ifdef BJ_PERF_CNT_EN
    #1;
    check("perf_br", BR_CNT, 32'd3);
    check("perf_miss", MISS_CNT, 32'd2);
`endif

    @(posedge CLK);
    #3;
    check("scoreboard_drained", 32'(cq.size() + rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
